ex_stage_md: RTL

EX_STAGE_MD -- requirements
Module: ex_stage_md

---
 rtl/ex_stage_md_pkg.sv | 43 ++++
 rtl/ex_stage_md_if.sv | 50 +++++
 rtl/alu.sv | 32 +++
 rtl/ex_stage_md_div.sv | 69 ++++++
 rtl/ex_stage_md.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/ex_stage_md_pkg.sv
// Shared encodings for the execute stage: multiply/divide ops, store sizes,
// FSM states and the one-hot ALU opcode bit positions.
package ex_stage_md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MUL   = 3'd1,
    MD_MULH  = 3'd2,
    MD_MULHU = 3'd3,
    MD_DIV   = 3'd4,
    MD_MOD   = 3'd5,
    MD_DIVU  = 3'd6,
    MD_MODU  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

endpackage

// File: rtl/ex_stage_md_if.sv
// Pipeline-side bundle of the execute stage: handshakes, payloads, data SRAM
// request and the forwarding tap.
interface ex_stage_md_if #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 12
);
  logic                ID_to_EX_valid;
  logic                EX_allow_in;
  logic                EX_to_MEM_valid;
  logic                MEM_allow_in;
  logic                flush;
  logic [XLEN-1:0]     in_pc;
  logic [XLEN-1:0]     in_src1;
  logic [XLEN-1:0]     in_src2;
  logic [ALU_OP_W-1:0] in_alu_op;
  logic [2:0]          in_md_op;
  logic                in_mem_we;
  logic [1:0]          in_mem_size;
  logic                in_res_from_mem;
  logic [4:0]          in_dest;
  logic                in_gr_we;
  logic [XLEN-1:0]     out_pc;
  logic [XLEN-1:0]     out_result;
  logic                out_res_from_mem;
  logic [4:0]          out_dest;
  logic                out_gr_we;
  logic                data_sram_en;
  logic [XLEN/8-1:0]   data_sram_we;
  logic [XLEN-1:0]     data_sram_addr;
  logic [XLEN-1:0]     data_sram_wdata;
  logic [4:0]          fwd_dest;
  logic [XLEN-1:0]     fwd_data;
  logic                fwd_busy;

  modport slave (
    input  ID_to_EX_valid, MEM_allow_in, flush, in_pc, in_src1, in_src2, in_alu_op,
           in_md_op, in_mem_we, in_mem_size, in_res_from_mem, in_dest, in_gr_we,
    output EX_allow_in, EX_to_MEM_valid, out_pc, out_result, out_res_from_mem, out_dest,
           out_gr_we, data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
           fwd_dest, fwd_data, fwd_busy
  );

  modport master (
    output ID_to_EX_valid, MEM_allow_in, flush, in_pc, in_src1, in_src2, in_alu_op,
           in_md_op, in_mem_we, in_mem_size, in_res_from_mem, in_dest, in_gr_we,
    input  EX_allow_in, EX_to_MEM_valid, out_pc, out_result, out_res_from_mem, out_dest,
           out_gr_we, data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
           fwd_dest, fwd_data, fwd_busy
  );
endinterface

// File: rtl/alu.sv
// One-hot opcode integer ALU; overlapping opcode bits OR their results.
module alu
  import ex_stage_md_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 12
) (
  input  logic [ALU_OP_W-1:0] op,
  input  logic [XLEN-1:0]     src1,
  input  logic [XLEN-1:0]     src2,
  output logic [XLEN-1:0]     result
);
  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] sh;
  assign sh = src2[SH_W-1:0];

  always_comb begin
    result = ({XLEN{op[ALU_ADD]}}  & (src1 + src2))
           | ({XLEN{op[ALU_SUB]}}  & (src1 - src2))
           | ({XLEN{op[ALU_SLT]}}  & XLEN'($signed(src1) < $signed(src2)))
           | ({XLEN{op[ALU_SLTU]}} & XLEN'(src1 < src2))
           | ({XLEN{op[ALU_AND]}}  & (src1 & src2))
           | ({XLEN{op[ALU_NOR]}}  & ~(src1 | src2))
           | ({XLEN{op[ALU_OR]}}   & (src1 | src2))
           | ({XLEN{op[ALU_XOR]}}  & (src1 ^ src2))
           | ({XLEN{op[ALU_SLL]}}  & (src1 << sh))
           | ({XLEN{op[ALU_SRL]}}  & (src1 >> sh))
           | ({XLEN{op[ALU_SRA]}}  & XLEN'($signed(src1) >>> sh))
           | ({XLEN{op[ALU_LUI]}}  & src2);
  end
endmodule

// File: rtl/ex_stage_md_div.sv
// Radix-2 restoring divider on operand magnitudes, one quotient bit per cycle.
// done stays high with the result held until the next start or kill.
module md_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);
  localparam int CNT_W = $clog2(XLEN);

  logic            busy, neg_q, neg_r, a_neg, b_neg;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] rem_p, quo, dvs, a_mag, b_mag;
  logic [XLEN:0]   trial;

  assign a_neg = is_signed & dividend[XLEN-1];
  assign b_neg = is_signed & divisor[XLEN-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;
  assign trial = {rem_p, quo[XLEN-1]} - {1'b0, dvs};

  // A zero divisor never fails the trial subtract, so the quotient fills with ones
  // and the remainder ends as the dividend; only the quotient sign flip is masked.
  always_ff @(posedge clk) begin
    if (reset || (kill && !start)) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      rem_p <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      done  <= 1'b0;
      cnt   <= CNT_W'(XLEN-1);
      rem_p <= '0;
      quo   <= a_mag;
      dvs   <= b_mag;
      neg_q <= (a_neg ^ b_neg) & (|divisor);
      neg_r <= a_neg;
    end else if (busy) begin
      if (trial[XLEN]) begin
        rem_p <= {rem_p[XLEN-2:0], quo[XLEN-1]};
        quo   <= {quo[XLEN-2:0], 1'b0};
      end else begin
        rem_p <= trial[XLEN-1:0];
        quo   <= {quo[XLEN-2:0], 1'b1};
      end
      cnt <= cnt - CNT_W'(1);
      if (cnt == '0) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign quot = neg_q ? -quo : quo;
  assign rem  = neg_r ? -rem_p : rem_p;
endmodule

// File: rtl/ex_stage_md.sv
// Execute stage with ALU, multi-cycle multiply, iterative divide, store
// byte-enable generation and a forwarding tap.
module ex_stage_md
  import ex_stage_md_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ALU_OP_W   = 12,
  parameter int MUL_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  ex_stage_md_if.slave  bus
);
  localparam int STRB_W = XLEN/8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int MCNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  md_state_e           state, state_n;
  logic                ex_valid, ready_go, capture, handoff, div_done, misalign;
  logic [XLEN-1:0]     pc_r, src1_r, src2_r, alu_res, md_res, mulh_res, div_quot, div_rem, wdata;
  logic [2*XLEN-1:0]   prod;
  logic [ALU_OP_W-1:0] alu_op_r;
  logic [2:0]          md_op_r;
  logic [1:0]          mem_size_r;
  logic                mem_we_r, res_from_mem_r, gr_we_r;
  logic [4:0]          dest_r;
  logic [MCNT_W-1:0]   mul_cnt, mul_cnt_n;
  logic [OFF_W-1:0]    off;
  logic [STRB_W-1:0]   strb;

  assign capture = bus.ID_to_EX_valid & bus.EX_allow_in;
  assign handoff = bus.EX_to_MEM_valid & bus.MEM_allow_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid       <= 1'b0;
      pc_r           <= '0;
      src1_r         <= '0;
      src2_r         <= '0;
      alu_op_r       <= '0;
      md_op_r        <= '0;
      mem_we_r       <= 1'b0;
      mem_size_r     <= '0;
      res_from_mem_r <= 1'b0;
      dest_r         <= '0;
      gr_we_r        <= 1'b0;
    end else if (capture) begin
      ex_valid       <= 1'b1;
      pc_r           <= bus.in_pc;
      src1_r         <= bus.in_src1;
      src2_r         <= bus.in_src2;
      alu_op_r       <= bus.in_alu_op;
      md_op_r        <= bus.in_md_op;
      mem_we_r       <= bus.in_mem_we;
      mem_size_r     <= bus.in_mem_size;
      res_from_mem_r <= bus.in_res_from_mem;
      dest_r         <= bus.in_dest;
      gr_we_r        <= bus.in_gr_we;
    end else if (bus.flush || handoff) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mul_cnt <= '0;
    end else begin
      state   <= state_n;
      mul_cnt <= mul_cnt_n;
    end
  end

  // A capture in the same cycle as a flush still starts the new instruction.
  always_comb begin
    state_n   = state;
    mul_cnt_n = mul_cnt;
    if (capture) begin
      if (bus.in_md_op[2]) begin
        state_n = DIV;
      end else if (bus.in_md_op != MD_NONE) begin
        state_n   = MUL;
        mul_cnt_n = MCNT_W'(MUL_CYCLES-1);
      end else begin
        state_n = IDLE;
      end
    end else if (bus.flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        MUL:     if (mul_cnt == '0) state_n = DONE; else mul_cnt_n = mul_cnt - MCNT_W'(1);
        DIV:     if (div_done) state_n = DONE;
        DONE:    if (handoff) state_n = IDLE;
        default: state_n = state;
      endcase
    end
  end

  alu #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W)) u_alu (
    .op(alu_op_r), .src1(src1_r), .src2(src2_r), .result(alu_res)
  );

  md_div #(.XLEN(XLEN)) u_div (
    .clk(clk), .reset(reset), .start(capture & bus.in_md_op[2]), .kill(bus.flush),
    .is_signed(~bus.in_md_op[1]), .dividend(bus.in_src1), .divisor(bus.in_src2),
    .done(div_done), .quot(div_quot), .rem(div_rem)
  );

  // Single unsigned multiplier; the signed high half is corrected from it.
  assign prod     = {{XLEN{1'b0}}, src1_r} * {{XLEN{1'b0}}, src2_r};
  assign mulh_res = prod[2*XLEN-1:XLEN] - (src1_r[XLEN-1] ? src2_r : '0)
                                        - (src2_r[XLEN-1] ? src1_r : '0);

  always_comb begin
    md_res = '0;
    case (md_op_r)
      MD_MUL:          md_res = prod[XLEN-1:0];
      MD_MULH:         md_res = mulh_res;
      MD_MULHU:        md_res = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU: md_res = div_quot;
      MD_MOD, MD_MODU: md_res = div_rem;
      default:         md_res = '0;
    endcase
  end

  assign ready_go            = (md_op_r == MD_NONE) || (state == DONE);
  assign bus.EX_allow_in     = ~ex_valid | (ready_go & bus.MEM_allow_in);
  assign bus.EX_to_MEM_valid = ex_valid & ready_go & ~bus.flush;
  assign bus.out_pc          = pc_r;
  assign bus.out_result      = (md_op_r == MD_NONE) ? alu_res : md_res;
  assign bus.out_res_from_mem = res_from_mem_r;
  assign bus.out_dest        = dest_r;
  assign bus.out_gr_we       = gr_we_r;

  assign off = alu_res[OFF_W-1:0];

  always_comb begin
    strb     = '0;
    misalign = 1'b0;
    wdata    = src2_r;
    case (mem_size_r)
      SZ_BYTE: begin strb = STRB_W'(1);  wdata = {STRB_W{src2_r[7:0]}}; end
      SZ_HALF: begin strb = STRB_W'(3);  misalign = off[0]; wdata = {(XLEN/16){src2_r[15:0]}}; end
      SZ_WORD: begin strb = STRB_W'(15); misalign = |off[1:0]; wdata = {(XLEN/32){src2_r[31:0]}}; end
      default: begin strb = STRB_W'(255); misalign = (XLEN != 64) || (|off); end
    endcase
  end

  // Gated by MEM acceptance so a stalled store fires only on the release cycle.
  assign bus.data_sram_we    = (ex_valid & mem_we_r & bus.MEM_allow_in & ~bus.flush & ~misalign)
                               ? (strb << off) : '0;
  assign bus.data_sram_en    = ex_valid;
  assign bus.data_sram_addr  = alu_res;
  assign bus.data_sram_wdata = wdata;

  assign bus.fwd_dest = (ex_valid & gr_we_r & ~res_from_mem_r) ? dest_r : 5'd0;
  assign bus.fwd_data = bus.out_result;
  assign bus.fwd_busy = ex_valid & (md_op_r != MD_NONE) & (state != DONE);
endmodule
